dac_sample_sched: RTL

Sample-rate scheduler that shares the single `spi2dac` serializer between two sample requesters. It generates the DAC sample tick internally, replacing the standalone divider. On each tick it grants one pending requester and latches that requester's word. It then pulses `load` into `spi2dac` and holds off further loads until the serial transfer has had time to complete. It sits between the signal sources (switch input, waveform generators) and `spi2dac` in the top level.

---
 rtl/dac_sample_sched.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dac_sample_sched.sv
`default_nettype none
// ============================================================================
// Module   : dac_sample_sched
// Purpose  : Sample-rate scheduler sharing one spi2dac serializer between two
//            sample requesters. Generates the DAC sample tick internally; on
//            each tick grants one pending requester, latches its word, pulses
//            dac_load, then holds off for XFER_CYCLES while the serial
//            transfer completes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DATA_W      : sample width (matches spi2dac data_in)
//   TICK_DIV    : sysclk cycles per sample tick (>= 2)
//   XFER_CYCLES : cycles spent in BUSY after a load (>= 1, < TICK_DIV)
// Ports
//   sysclk      in  : system clock
//   rst_n       in  : synchronous active-low reset
//   req0/data0  in  : requester 0 pending flag / sample
//   req1/data1  in  : requester 1 pending flag / sample
//   ack0/ack1   out : one-cycle pulse, that requester's sample was taken
//   dac_data    out : word to spi2dac data_in, held between loads
//   dac_load    out : one-cycle load strobe to spi2dac
//   dac_chan    out : channel granted for the current dac_data
//   busy        out : high while in LOAD or BUSY
//   tick_miss   out : sticky, a tick arrived while not IDLE
// Configuration
//   DAC_SCHED_RR_EN defined   : round-robin arbitration between requesters
//   DAC_SCHED_RR_EN undefined : fixed priority, channel 0 wins
// ============================================================================
module dac_sample_sched #(
  parameter int DATA_W      = 10,
  parameter int TICK_DIV    = 5000,
  parameter int XFER_CYCLES = 1000
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_load,
  output logic              dac_chan,
  output logic              busy,
  output logic              tick_miss
);

  localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int XFER_W = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [XFER_W-1:0] XFER_LAST = XFER_W'(XFER_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BUSY = 2'd2
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   tick_cnt;
  logic [XFER_W-1:0]  xfer_cnt;
  logic               tick;
  logic               any_req;
  logic               win_chan;
  logic               grant;

  // --------------------------------------------------------------------------
  // Free-running sample tick counter; runs in every state so the sample
  // rate never drifts with transfer activity.
  // --------------------------------------------------------------------------
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration. Requests are only looked at in the tick cycle, so a request
  // rising between ticks simply waits for the next one.
  // --------------------------------------------------------------------------
  assign any_req = req0 | req1;

`ifdef DAC_SCHED_RR_EN
  logic last_grant;

  // With both requesting, the channel not granted last wins. Reset value 1
  // makes channel 0 the first winner.
  assign win_chan = (req0 & req1) ? ~last_grant : ~req0;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (state == ST_LOAD) begin
      last_grant <= dac_chan;
    end
  end
`else
  // Fixed priority: channel 1 only wins when channel 0 is idle.
  assign win_chan = ~req0;
`endif

  assign grant = (state == ST_IDLE) && tick && any_req;

  // --------------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dac_data  <= '0;
      dac_chan  <= 1'b0;
      xfer_cnt  <= '0;
      tick_miss <= 1'b0;
    end else begin
      state <= next_state;

      // Output word and channel only change on entry to LOAD.
      if (grant) begin
        dac_data <= win_chan ? data1 : data0;
        dac_chan <= win_chan;
      end

      if (state == ST_LOAD) begin
        xfer_cnt <= XFER_LAST;
      end else if ((state == ST_BUSY) && (xfer_cnt != '0)) begin
        xfer_cnt <= xfer_cnt - XFER_W'(1);
      end

      // A tick outside IDLE is dropped; remember that it happened.
      if (tick && (state != ST_IDLE)) begin
        tick_miss <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    dac_load   = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    busy       = 1'b0;

    case (state)
      ST_IDLE: begin
        // A tick with no request is consumed without a load.
        if (tick && any_req) begin
          next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        dac_load   = 1'b1;
        ack0       = ~dac_chan;
        ack1       = dac_chan;
        busy       = 1'b1;
        next_state = ST_BUSY;
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (xfer_cnt == '0) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
